// File: rtl/mesm6_io_master.sv
// Initiator for the MESM-6 peripheral bus: turns single-word CPU read/write requests into
// one-cycle peripheral strobes, waits for done (or times out) and returns done/error/rdata.
module mesm6_io_master #(
    parameter int NPER    = 4,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [14:0]          io_addr,
    input  logic                 io_read,
    input  logic                 io_write,
    input  logic [47:0]          io_wdata,
    output logic [47:0]          io_rdata,
    output logic                 io_done,
    output logic                 io_error,
    output logic                 io_busy,
    output logic [14:0]          per_addr,
    output logic [47:0]          per_wdata,
    output logic [NPER-1:0]      per_read,
    output logic [NPER-1:0]      per_write,
    input  logic [NPER*48-1:0]   per_rdata,
    input  logic [NPER-1:0]      per_done
);

    localparam int IDXW = 15 - SEL_LSB;
    localparam int CW   = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic                op_write_q, op_write_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [14:0]         per_addr_q, per_addr_d;
    logic [47:0]         per_wdata_q, per_wdata_d;
    logic [NPER-1:0]     per_read_q, per_read_d;
    logic [NPER-1:0]     per_write_q, per_write_d;
    logic                io_done_q, io_done_d;
    logic                io_error_q, io_error_d;
    logic                io_busy_q, io_busy_d;
    logic [47:0]         io_rdata_q, io_rdata_d;

    logic [IDXW-1:0]     acc_idx_s;
    logic [NPER-1:0]     acc_onehot_s;
    logic                acc_mapped_s;
    logic                done_sel_s;
    logic [47:0]         rdata_sel_s;

    assign acc_idx_s = io_addr[14:SEL_LSB];

    // Decode the incoming index and select the active peripheral's done/rdata
    always_comb begin
        done_sel_s  = 1'b0;
        rdata_sel_s = 48'd0;
        for (int i = 0; i < NPER; i++) begin
            acc_onehot_s[i] = (acc_idx_s == IDXW'(i));
            done_sel_s      = done_sel_s | (per_done[i] & (idx_q == IDXW'(i)));
            rdata_sel_s     = rdata_sel_s | (per_rdata[48*i +: 48] & {48{idx_q == IDXW'(i)}});
        end
        acc_mapped_s = |acc_onehot_s;
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_write_d  = op_write_q;
        cnt_d       = cnt_q;
        per_addr_d  = per_addr_q;
        per_wdata_d = per_wdata_q;
        per_read_d  = '0;
        per_write_d = '0;
        io_done_d   = 1'b0;
        io_error_d  = 1'b0;
        io_busy_d   = io_busy_q;
        io_rdata_d  = io_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (io_read | io_write) begin
                    per_addr_d  = io_addr;
                    per_wdata_d = io_wdata;
                    op_write_d  = io_write;
                    idx_d       = acc_idx_s;
                    io_busy_d   = 1'b1;
                    if ((io_read & io_write) | ~acc_mapped_s) begin
                        state_d    = ST_RESP;
                        io_done_d  = 1'b1;
                        io_error_d = 1'b1;
                        io_rdata_d = 48'd0;
                    end else begin
                        state_d     = ST_ISSUE;
                        per_read_d  = acc_onehot_s & {NPER{io_read}};
                        per_write_d = acc_onehot_s & {NPER{io_write}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
                if (done_sel_s) begin
                    state_d    = ST_RESP;
                    io_done_d  = 1'b1;
                    io_rdata_d = op_write_q ? 48'd0 : rdata_sel_s;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done_sel_s) begin
                    state_d    = ST_RESP;
                    io_done_d  = 1'b1;
                    io_rdata_d = op_write_q ? 48'd0 : rdata_sel_s;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d    = ST_RESP;
                    io_done_d  = 1'b1;
                    io_error_d = 1'b1;
                    io_rdata_d = 48'd0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                io_busy_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                io_busy_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops strobes and abandons any pending request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            op_write_q  <= 1'b0;
            cnt_q       <= '0;
            per_addr_q  <= 15'd0;
            per_wdata_q <= 48'd0;
            per_read_q  <= '0;
            per_write_q <= '0;
            io_done_q   <= 1'b0;
            io_error_q  <= 1'b0;
            io_busy_q   <= 1'b0;
            io_rdata_q  <= 48'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_write_q  <= op_write_d;
            cnt_q       <= cnt_d;
            per_addr_q  <= per_addr_d;
            per_wdata_q <= per_wdata_d;
            per_read_q  <= per_read_d;
            per_write_q <= per_write_d;
            io_done_q   <= io_done_d;
            io_error_q  <= io_error_d;
            io_busy_q   <= io_busy_d;
            io_rdata_q  <= io_rdata_d;
        end
    end

    assign io_rdata  = io_rdata_q;
    assign io_done   = io_done_q;
    assign io_error  = io_error_q;
    assign io_busy   = io_busy_q;
    assign per_addr  = per_addr_q;
    assign per_wdata = per_wdata_q;
    assign per_read  = per_read_q;
    assign per_write = per_write_q;

endmodule

// File: tb/tb_mesm6_io_master.sv
// Scoreboard bench for mesm6_io_master: stimulus pushes expected responses and strobes,
// a negedge monitor pops and compares them when the DUT presents them.
module tb_mesm6_io_master;

    localparam int NPER    = 4;
    localparam int TIMEOUT = 64;

    logic               clk;
    logic               reset;
    logic [14:0]        io_addr;
    logic               io_read;
    logic               io_write;
    logic [47:0]        io_wdata;
    logic [47:0]        io_rdata;
    logic               io_done;
    logic               io_error;
    logic               io_busy;
    logic [14:0]        per_addr;
    logic [47:0]        per_wdata;
    logic [NPER-1:0]    per_read;
    logic [NPER-1:0]    per_write;
    logic [NPER*48-1:0] per_rdata;
    logic [NPER-1:0]    per_done;

    logic done0, done1, stray3;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        int          done_cyc;
        logic [47:0] rdata;
        logic        err;
        bit          chk_wdata;
        logic [47:0] wdata;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [3:0]  rd;
        logic [3:0]  wr;
    } strobe_t;

    resp_t   exp_q[$];
    strobe_t stb_q[$];

    mesm6_io_master #(.NPER(NPER), .SEL_LSB(12), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .io_addr(io_addr), .io_read(io_read), .io_write(io_write), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_done(io_done), .io_error(io_error), .io_busy(io_busy),
        .per_addr(per_addr), .per_wdata(per_wdata), .per_read(per_read), .per_write(per_write),
        .per_rdata(per_rdata), .per_done(per_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // idx 0 and idx 1 answer one cycle after their strobe; idx 2 is silent; idx 3 is driven by hand
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            done0 <= 1'b0;
            done1 <= 1'b0;
        end else begin
            done0 <= per_read[0] | per_write[0];
            done1 <= per_read[1] | per_write[1];
        end
    end

    assign per_done  = {stray3, 1'b0, done1, done0};
    assign per_rdata = {48'h0000_0000_BEEF, 48'h0000_0000_DEAD,
                        48'hA5A5_0000_0000 ^ {33'd0, per_addr},
                        48'h0000_FFFF_0000 ^ {33'd0, per_addr}};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare strobes and completions against the expectation queues
    always @(negedge clk) begin
        if (reset) begin
            if (stb_q.size() > 0 && stb_q[0].cyc == cyc) begin
                chk("per_read", 64'(per_read), 64'(stb_q[0].rd));
                chk("per_write", 64'(per_write), 64'(stb_q[0].wr));
                void'(stb_q.pop_front());
            end else if ((per_read | per_write) != 4'd0) begin
                chk("unexpected_strobe", 64'({per_read, per_write}), 64'd0);
            end
            if (exp_q.size() > 0 && exp_q[0].done_cyc == cyc) begin
                chk("io_done", 64'(io_done), 64'd1);
                chk("io_error", 64'(io_error), 64'(exp_q[0].err));
                chk("io_rdata", 64'(io_rdata), 64'(exp_q[0].rdata));
                chk("io_busy_at_done", 64'(io_busy), 64'd1);
                if (exp_q[0].chk_wdata) begin
                    chk("per_wdata", 64'(per_wdata), 64'(exp_q[0].wdata));
                end
                void'(exp_q.pop_front());
            end else if (io_done) begin
                chk("unexpected_io_done", 64'(io_done), 64'd0);
            end
        end
    end

    task automatic wait_idle();
        int n;
        for (n = 0; n < 200; n++) begin
            if (exp_q.size() == 0 && stb_q.size() == 0) break;
            @(negedge clk);
        end
        if (n == 200) begin
            chk("response_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            stb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [14:0] addr,
                         input logic [47:0] wdata, input int lat, input logic [47:0] exp_rdata,
                         input logic exp_err, input logic [3:0] srd, input logic [3:0] swr);
        resp_t   r;
        strobe_t s;
        @(negedge clk);
        io_read  = rd;
        io_write = wr;
        io_addr  = addr;
        io_wdata = wdata;
        r.done_cyc  = cyc + lat;
        r.rdata     = exp_rdata;
        r.err       = exp_err;
        r.chk_wdata = wr & ~rd;
        r.wdata     = wdata;
        exp_q.push_back(r);
        if ((srd | swr) != 4'd0) begin
            s.cyc = cyc + 1;
            s.rd  = srd;
            s.wr  = swr;
            stb_q.push_back(s);
        end
        @(negedge clk);
        io_read  = 1'b0;
        io_write = 1'b0;
    endtask

    initial begin
        strobe_t s;
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        io_addr  = 15'd0;
        io_read  = 1'b0;
        io_write = 1'b0;
        io_wdata = 48'd0;
        stray3   = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({io_done, io_error, io_busy, per_read, per_write}), 64'd0);
        chk("reset_data", 64'({per_addr, io_rdata}), 64'd0);
        chk("reset_wdata", 64'(per_wdata), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // read idx 1, write idx 1
        issue(1'b1, 1'b0, 15'o10005, 48'd0, 3, 48'hA5A5_0000_1005, 1'b0, 4'b0010, 4'b0000);
        wait_idle();
        issue(1'b0, 1'b1, 15'o10006, 48'h123, 3, 48'd0, 1'b0, 4'b0000, 4'b0010);
        wait_idle();
        // read idx 0
        issue(1'b1, 1'b0, 15'o00003, 48'd0, 3, 48'h0000_FFFF_0003, 1'b0, 4'b0001, 4'b0000);
        wait_idle();
        // timeout on silent idx 2, with stray idx-3 done pulses inside WAIT
        issue(1'b1, 1'b0, 15'o20000, 48'd0, TIMEOUT + 2, 48'd0, 1'b1, 4'b0100, 4'b0000);
        stray3 = 1'b1;
        @(negedge clk);
        stray3 = 1'b0;
        wait_idle();
        // unmapped and read+write conflict
        issue(1'b1, 1'b0, 15'o70000, 48'd0, 1, 48'd0, 1'b1, 4'b0000, 4'b0000);
        wait_idle();
        issue(1'b1, 1'b1, 15'o10005, 48'h55, 1, 48'd0, 1'b1, 4'b0000, 4'b0000);
        wait_idle();
        // second request in cycle 1 is dropped
        @(negedge clk);
        io_read = 1'b1;
        io_addr = 15'o10005;
        begin
            resp_t r;
            r.done_cyc = cyc + 3; r.rdata = 48'hA5A5_0000_1005; r.err = 1'b0;
            r.chk_wdata = 1'b0; r.wdata = 48'd0;
            exp_q.push_back(r);
            s.cyc = cyc + 1; s.rd = 4'b0010; s.wr = 4'b0000;
            stb_q.push_back(s);
        end
        @(negedge clk);
        io_addr = 15'o00007;
        @(negedge clk);
        io_read = 1'b0;
        wait_idle();
        // stray done while idle is ignored
        stray3 = 1'b1;
        @(negedge clk);
        stray3 = 1'b0;
        repeat (3) @(negedge clk);

        // reset in WAIT kills the transaction
        @(negedge clk);
        io_read = 1'b1;
        io_addr = 15'o20001;
        s.cyc = cyc + 1; s.rd = 4'b0100; s.wr = 4'b0000;
        stb_q.push_back(s);
        @(negedge clk);
        io_read = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_in_wait", 64'(io_busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_ctrl", 64'({io_done, io_error, io_busy, per_read, per_write}), 64'd0);
        chk("async_reset_data", 64'({per_addr, io_rdata}), 64'd0);
        chk("async_reset_wdata", 64'(per_wdata), 64'd0);
        exp_q.delete();
        stb_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        issue(1'b1, 1'b0, 15'o10005, 48'd0, 3, 48'hA5A5_0000_1005, 1'b0, 4'b0010, 4'b0000);
        wait_idle();
        repeat (4) @(negedge clk);
        chk("rdata_held", 64'(io_rdata), 64'hA5A5_0000_1005);
        chk("queues_drained", 64'(exp_q.size() + stb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
